// File: rtl/bcd_entry_accumulator_if.sv
// bcd_entry_accumulator_if: digit-entry and operand-output handshake bundle.
interface bcd_entry_accumulator_if #(
    parameter int VAL_W = 7,
    parameter int IDX_W = 1,
    parameter int CNT_W = 2
);
    logic             digit_valid;
    logic [3:0]       digit;
    logic             digit_ready;
    logic             enter;
    logic             backspace;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [VAL_W-1:0] out_value;
    logic [IDX_W-1:0] out_idx;
    logic [CNT_W-1:0] out_ndigits;
    logic             err;

    modport master (
        output digit_valid, digit, enter, backspace, clear, out_ready,
        input  digit_ready, out_valid, out_value, out_idx, out_ndigits, err
    );

    modport slave (
        input  digit_valid, digit, enter, backspace, clear, out_ready,
        output digit_ready, out_valid, out_value, out_idx, out_ndigits, err
    );
endinterface

// File: rtl/bcd_entry_accumulator.sv
// bcd_entry_accumulator: buffers BCD keypad digits, converts them to binary one
// digit per clock on enter, and hands each operand out with a rotating index.
module bcd_entry_accumulator #(
    parameter int NUM_DIGITS   = 2,
    parameter int NUM_OPERANDS = 2,
    parameter int VAL_W        = 7,
    parameter int IDX_W        = 1,
    parameter int CNT_W        = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    bcd_entry_accumulator_if.slave bus
);
    typedef enum logic [1:0] {ENTRY, CONVERT, OUT} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_step;
    logic [3:0]       r_buf [NUM_DIGITS];
    logic [VAL_W-1:0] r_acc;
    logic [IDX_W-1:0] r_idx;
    logic             r_err;
    logic [3:0]       w_dig;
    logic [VAL_W+3:0] w_mac;

    always_comb begin
        w_dig = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (CNT_W'(i) == r_step) w_dig = r_buf[i];
    end

    // acc*10 + digit as two shifts, kept 4 bits wide so nothing wraps before truncation
    assign w_mac = ({4'b0, r_acc} << 3) + ({4'b0, r_acc} << 1) + {{VAL_W{1'b0}}, w_dig};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ENTRY;
            r_cnt   <= '0;
            r_step  <= '0;
            r_buf   <= '{default: '0};
            r_acc   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ENTRY: begin
                    if (bus.clear) r_cnt <= '0;
                    else if (bus.backspace) begin
                        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    end else if (bus.enter) begin
                        r_acc   <= '0;
                        r_step  <= '0;
                        r_state <= (r_cnt == '0) ? OUT : CONVERT;
                    end else if (bus.digit_valid) begin
                        if (bus.digit <= 4'd9 && r_cnt < CNT_W'(NUM_DIGITS)) begin
                            for (int i = 0; i < NUM_DIGITS; i++)
                                if (CNT_W'(i) == r_cnt) r_buf[i] <= bus.digit;
                            r_cnt <= r_cnt + 1'b1;
                        end else r_err <= 1'b1;
                    end
                end
                CONVERT: begin
                    r_acc  <= VAL_W'(w_mac);
                    r_step <= r_step + 1'b1;
                    if (r_step == r_cnt - 1'b1) r_state <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_idx   <= (r_idx == IDX_W'(NUM_OPERANDS - 1)) ? '0 : r_idx + 1'b1;
                        r_cnt   <= '0;
                        r_state <= ENTRY;
                    end
                end
                default: r_state <= ENTRY;
            endcase
        end
    end

    assign bus.digit_ready = (r_state == ENTRY);
    assign bus.out_valid   = (r_state == OUT);
    assign bus.out_value   = r_acc;
    assign bus.out_idx     = r_idx;
    assign bus.out_ndigits = r_cnt;
    assign bus.err         = r_err;
endmodule
